// File: rtl/alu_execute_if.sv
// Issue and writeback signals between the register file and the execute stage.
interface alu_execute_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned OP_WIDTH   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  wb_valid;
    logic                  wb_rw;
    logic [ADDR_WIDTH-1:0] wb_dest;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  flag_z;
    logic                  flag_n;
    logic                  flag_c;
    logic                  flag_v;
    logic                  busy;

    // Issuer / register-file side
    modport master (
        output in_valid, op, a, b, dest,
        input  in_ready, wb_valid, wb_rw, wb_dest, wb_data,
               flag_z, flag_n, flag_c, flag_v, busy
    );

    // Execute stage side
    modport slave (
        input  in_valid, op, a, b, dest,
        output in_ready, wb_valid, wb_rw, wb_dest, wb_data,
               flag_z, flag_n, flag_c, flag_v, busy
    );
endinterface

// File: rtl/alu_execute.sv
// Execute stage: single-cycle ALU plus a 16-cycle iterative shift-add multiplier,
// driving the register file write port and the status flags.
module alu_execute (
    input  logic         clk,
    input  logic         reset,
    alu_execute_if.slave bus
);
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned OP_WIDTH   = 4;
    localparam int unsigned CNT_WIDTH  = 4;

    localparam logic [OP_WIDTH-1:0] OP_ADD = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_AND = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_NOT = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_SHL = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_SHR = 4'd7;
    localparam logic [OP_WIDTH-1:0] OP_SRA = 4'd8;
    localparam logic [OP_WIDTH-1:0] OP_MUL = 4'd9;
    localparam logic [OP_WIDTH-1:0] OP_MOV = 4'd10;
    localparam logic [OP_WIDTH-1:0] OP_SLT = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  flag_z_q, flag_z_d;
    logic                  flag_n_q, flag_n_d;
    logic                  flag_c_q, flag_c_d;
    logic                  flag_v_q, flag_v_d;

    logic                  in_ready;
    logic                  accept;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] diff;
    logic [3:0]            shamt;
    logic                  slt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c;
    logic                  alu_v;
    logic                  alu_wr;
    logic [DATA_WIDTH-1:0] acc_sum;

    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign accept   = bus.in_valid && in_ready;
    assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff     = bus.a - bus.b;
    assign shamt    = bus.b[3:0];
    assign slt      = $signed(bus.a) < $signed(bus.b);
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : DATA_WIDTH'(0));

    // Single-cycle result, carry/overflow and write-enable for the issued opcode
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum_ext[DATA_WIDTH-1:0];
                alu_c   = sum_ext[DATA_WIDTH];
                alu_v   = (bus.a[15] == bus.b[15]) && (sum_ext[15] != bus.a[15]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = bus.a < bus.b;
                alu_v   = (bus.a[15] != bus.b[15]) && (diff[15] != bus.a[15]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOT:  alu_res = ~bus.a;
            OP_SHL:  alu_res = bus.a << shamt;
            OP_SHR:  alu_res = bus.a >> shamt;
            OP_SRA:  alu_res = DATA_WIDTH'($signed(bus.a) >>> shamt);
            OP_MOV:  alu_res = bus.b;
            OP_SLT:  alu_res = DATA_WIDTH'(slt);
            default: alu_wr  = 1'b0;
        endcase
    end

    // Next-state, multiplier datapath and writeback register updates
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
        flag_c_d   = flag_c_q;
        flag_v_d   = flag_v_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else if (alu_wr) begin
                        wb_valid_d = 1'b1;
                        wb_dest_d  = bus.dest;
                        wb_data_d  = alu_res;
                        flag_z_d   = (alu_res == '0);
                        flag_n_d   = alu_res[15];
                        flag_c_d   = alu_c;
                        flag_v_d   = alu_v;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(15)) begin
                    wb_valid_d = 1'b1;
                    wb_dest_d  = wb_dest_q;
                    wb_data_d  = acc_sum;
                    flag_z_d   = (acc_sum == '0);
                    flag_n_d   = acc_sum[15];
                    flag_c_d   = 1'b0;
                    flag_v_d   = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // MUL destination is captured at accept so it survives the iteration
    logic [ADDR_WIDTH-1:0] mul_dest_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_dest_q <= '0;
        end else if (accept && bus.op == OP_MUL) begin
            mul_dest_q <= bus.dest;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_v_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= (state_q == ST_MUL && wb_valid_d) ? mul_dest_q : wb_dest_d;
            wb_data_q  <= wb_data_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            flag_c_q   <= flag_c_d;
            flag_v_q   <= flag_v_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rw    = wb_valid_q;
    assign bus.wb_dest  = wb_dest_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.flag_z   = flag_z_q;
    assign bus.flag_n   = flag_n_q;
    assign bus.flag_c   = flag_c_q;
    assign bus.flag_v   = flag_v_q;
    assign bus.busy     = (state_q == ST_MUL);
endmodule

// File: tb/tb_alu_execute.sv
// Directed self-checking bench for alu_execute.
module tb_alu_execute;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    alu_execute_if bus ();

    alu_execute dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs can be sampled and inputs driven
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [15:0] av,
                         input logic [15:0] bv, input logic [3:0] d);
        bus.in_valid = v;
        bus.op       = o;
        bus.a        = av;
        bus.b        = bv;
        bus.dest     = d;
    endtask

    task automatic check_wb(input string tag, input logic [3:0] d, input logic [15:0] data,
                            input logic z, input logic n, input logic c, input logic v);
        check({tag, ".valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, ".rw"},    32'(bus.wb_rw),    32'd1);
        check({tag, ".dest"},  32'(bus.wb_dest),  32'(d));
        check({tag, ".data"},  32'(bus.wb_data),  32'(data));
        check({tag, ".znvc"},  32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}),
              32'({z, n, c, v}));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);

        // Reset held two cycles
        step();
        step();
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst.wb_rw",    32'(bus.wb_rw),    32'd0);
        check("rst.wb_dest",  32'(bus.wb_dest),  32'd0);
        check("rst.wb_data",  32'(bus.wb_data),  32'd0);
        check("rst.flags",    32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'd0);
        check("rst.busy",     32'(bus.busy),     32'd0);
        reset = 1'b0;
        #1;
        check("idle.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("idle.wb_valid", 32'(bus.wb_valid), 32'd0);

        // ADD with signed overflow, then ADD with carry-out to zero
        drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'd3);
        step();
        check_wb("add_ovf", 4'd3, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4'd0, 16'hFFFF, 16'h0001, 4'd4);
        step();
        check_wb("add_carry", 4'd4, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
        step();
        check("pulse_end.valid", 32'(bus.wb_valid), 32'd0);
        check("pulse_end.hold",  32'(bus.wb_dest),  32'd4);

        // Back-to-back SUB, SRA, SLT
        drive(1'b1, 4'd1, 16'd5, 16'd7, 4'd1);
        step();
        check_wb("b2b_sub", 4'd1, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'd8, 16'h8000, 16'd4, 4'd2);
        step();
        check_wb("b2b_sra", 4'd2, 16'hF800, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'd11, 16'hFFFF, 16'd1, 4'd6);
        step();
        check_wb("b2b_slt", 4'd6, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
        step();
        check("b2b_end.valid", 32'(bus.wb_valid), 32'd0);

        // MUL with in_valid held high throughout; ADD 1+1 waits behind it
        drive(1'b1, 4'd9, 16'h0123, 16'h0045, 4'd9);
        step();
        drive(1'b1, 4'd0, 16'd1, 16'd1, 4'd2);
        for (int i = 0; i < 16; i++) begin
            check("mul.busy",     32'(bus.busy),     32'd1);
            check("mul.in_ready", 32'(bus.in_ready), 32'd0);
            check("mul.wb_valid", 32'(bus.wb_valid), 32'd0);
            step();
        end
        check_wb("mul_done", 4'd9, 16'h4E6F, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mul_done.busy",     32'(bus.busy),     32'd0);
        check("mul_done.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_wb("post_mul_add", 4'd2, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
        step();

        // Reset in the middle of a MUL aborts it
        drive(1'b1, 4'd9, 16'd3, 16'd4, 4'd7);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("abort.busy",     32'(bus.busy),     32'd0);
        check("abort.in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 14; i++) begin
            check("abort.wb_valid", 32'(bus.wb_valid), 32'd0);
            step();
        end
        drive(1'b1, 4'd0, 16'd1, 16'd1, 4'd5);
        step();
        check_wb("abort_add", 4'd5, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        // NOP leaves flags and writeback registers alone
        drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'd3);
        step();
        check_wb("pre_nop", 4'd3, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4'd12, 16'h1234, 16'h5678, 4'd8);
        step();
        check("nop.wb_valid", 32'(bus.wb_valid), 32'd0);
        check("nop.wb_rw",    32'(bus.wb_rw),    32'd0);
        check("nop.wb_data",  32'(bus.wb_data),  32'h8000);
        check("nop.flags",    32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'b0101);

        // Shift amount from b[3:0] only, plus a few logic ops
        drive(1'b1, 4'd6, 16'h00F0, 16'h0010, 4'd1);
        step();
        check_wb("shl0", 4'd1, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 16'h8000, 16'h000F, 4'd2);
        step();
        check_wb("shr15", 4'd2, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 16'h00FF, 16'h0000, 4'd3);
        step();
        check_wb("not", 4'd3, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'd4, 16'hA5A5, 16'hFFFF, 4'd4);
        step();
        check_wb("xor", 4'd4, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd10, 16'h1234, 16'h0000, 4'd5);
        step();
        check_wb("mov", 4'd5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'h8000, 16'h0001, 4'd6);
        step();
        check_wb("sub_ovf", 4'd6, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
